// File: rtl/axil_cfg_slave_if.sv
// AXI-Lite (no B channel) bus bundle between the config controller and a register target.
// The master drives the valids, addresses, write data and rready; the slave drives the readies, rvalid and rdata.
interface axil_cfg_slave_if #(
  parameter int pADDR_WIDTH = 15,
  parameter int pDATA_WIDTH = 32
);
  logic                       axi_awvalid;
  logic [pADDR_WIDTH-1:0]     axi_awaddr;
  logic                       axi_awready;
  logic                       axi_wvalid;
  logic [pDATA_WIDTH-1:0]     axi_wdata;
  logic [pDATA_WIDTH/8-1:0]   axi_wstrb;
  logic                       axi_wready;
  logic                       axi_arvalid;
  logic [pADDR_WIDTH-1:0]     axi_araddr;
  logic                       axi_arready;
  logic                       axi_rvalid;
  logic [pDATA_WIDTH-1:0]     axi_rdata;
  logic                       axi_rready;

  modport master (
    output axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb,
    output axi_arvalid, axi_araddr, axi_rready,
    input  axi_awready, axi_wready, axi_arready, axi_rvalid, axi_rdata
  );

  modport slave (
    input  axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb,
    input  axi_arvalid, axi_araddr, axi_rready,
    output axi_awready, axi_wready, axi_arready, axi_rvalid, axi_rdata
  );
endinterface

// File: rtl/axil_cfg_slave.sv
// AXI-Lite config register target (CTRL, STATUS, SCRATCH, WR_CNT). Writes are acked one cycle after aw+w valid and commit on the following edge.
// Reads return data two cycles after arvalid; rdata is held until rready. Writes and reads run concurrently and independently.
module axil_cfg_slave #(
  parameter int pADDR_WIDTH = 15,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axi_clk,
  input  logic                   axi_reset_n,
  input  logic                   cc_enable,
  axil_cfg_slave_if.slave        axi,
  input  logic [pDATA_WIDTH-1:0] sts_in,
  output logic [pDATA_WIDTH-1:0] cfg_ctrl,
  output logic                   cfg_wr_pulse
);
  localparam int STRB_W = pDATA_WIDTH / 8;
  localparam logic [9:0] OFS_CTRL    = 10'd0;
  localparam logic [9:0] OFS_STATUS  = 10'd1;
  localparam logic [9:0] OFS_SCRATCH = 10'd2;
  localparam logic [9:0] OFS_WR_CNT  = 10'd3;

  typedef enum logic {W_IDLE, W_ACK} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t               w_state, w_next;
  r_state_t               r_state, r_next;
  logic [pDATA_WIDTH-1:0] ctrl_q, scratch_q, rdata_q, rd_mux;
  logic [15:0]            wr_cnt_q;
  logic [9:0]             w_idx, r_idx;
  logic                   unused_addr_bits;

  // Only word offsets within the 4 KB window decode; upper and byte-offset bits alias.
  assign w_idx = axi.axi_awaddr[11:2];
  assign r_idx = axi.axi_araddr[11:2];
  assign unused_addr_bits = ^{axi.axi_awaddr[pADDR_WIDTH-1:12], axi.axi_awaddr[1:0],
                              axi.axi_araddr[pADDR_WIDTH-1:12], axi.axi_araddr[1:0]};

  assign axi.axi_awready = (w_state == W_ACK);
  assign axi.axi_wready  = (w_state == W_ACK);
  assign axi.axi_arready = (r_state == R_ADDR);
  assign axi.axi_rvalid  = (r_state == R_DATA);
  assign axi.axi_rdata   = rdata_q;
  assign cfg_ctrl        = ctrl_q;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (cc_enable && axi.axi_awvalid && axi.axi_wvalid) w_next = W_ACK;
      W_ACK:   w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (cc_enable && axi.axi_arvalid) r_next = R_ADDR;
      R_ADDR:  r_next = R_DATA;
      R_DATA:  if (axi.axi_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Write commit happens on the edge that ends W_ACK, with the master still holding addr/data.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      ctrl_q       <= '0;
      scratch_q    <= '0;
      wr_cnt_q     <= '0;
      cfg_wr_pulse <= 1'b0;
    end else begin
      cfg_wr_pulse <= 1'b0;
      if (w_state == W_ACK) begin
        for (int i = 0; i < STRB_W; i++) begin
          if (axi.axi_wstrb[i]) begin
            if (w_idx == OFS_CTRL)    ctrl_q[8*i +: 8]    <= axi.axi_wdata[8*i +: 8];
            if (w_idx == OFS_SCRATCH) scratch_q[8*i +: 8] <= axi.axi_wdata[8*i +: 8];
          end
        end
        cfg_wr_pulse <= (w_idx == OFS_CTRL);
        wr_cnt_q     <= (w_idx == OFS_WR_CNT) ? 16'd0 : wr_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (r_idx)
      OFS_CTRL:    rd_mux = ctrl_q;
      OFS_STATUS:  rd_mux = sts_in;
      OFS_SCRATCH: rd_mux = scratch_q;
      OFS_WR_CNT:  rd_mux = {{(pDATA_WIDTH-16){1'b0}}, wr_cnt_q};
      default:     rd_mux = '0;
    endcase
  end

  // Captured from pre-commit register values, so a same-edge write is not visible to this read.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      rdata_q <= '0;
    end else if (r_state == R_ADDR) begin
      rdata_q <= rd_mux;
    end else if (r_state == R_DATA && axi.axi_rready) begin
      rdata_q <= '0;
    end
  end
endmodule

// File: tb/tb_axil_cfg_slave.sv
// Directed self-checking bench for axil_cfg_slave: register map, handshakes, strobes, counter wrap and reset.
`timescale 1ns/1ps
module tb_axil_cfg_slave;
  logic        axi_clk = 1'b0;
  logic        axi_reset_n = 1'b0;
  logic        cc_enable = 1'b0;
  logic [31:0] sts_in = 32'h0;
  logic [31:0] cfg_ctrl;
  logic        cfg_wr_pulse;
  int          total = 0;
  int          bad = 0;

  axil_cfg_slave_if #(.pADDR_WIDTH(15), .pDATA_WIDTH(32)) axi();

  axil_cfg_slave #(.pADDR_WIDTH(15), .pDATA_WIDTH(32)) dut (
    .axi_clk      (axi_clk),
    .axi_reset_n  (axi_reset_n),
    .cc_enable    (cc_enable),
    .axi          (axi),
    .sts_in       (sts_in),
    .cfg_ctrl     (cfg_ctrl),
    .cfg_wr_pulse (cfg_wr_pulse)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic do_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    axi.axi_awaddr = a; axi.axi_wdata = d; axi.axi_wstrb = s;
    axi.axi_awvalid = 1'b1; axi.axi_wvalid = 1'b1;
    do begin tick(); n++; end while (!axi.axi_awready && n < 20);
    if (!axi.axi_awready) begin
      total++; bad++;
      $display("FAIL write_timeout addr=%h got no awready, required ack", a);
    end
    tick();
    axi.axi_awvalid = 1'b0; axi.axi_wvalid = 1'b0;
  endtask

  task automatic do_read(input logic [14:0] a, output logic [31:0] d);
    int n = 0;
    axi.axi_araddr = a; axi.axi_arvalid = 1'b1;
    do begin tick(); n++; end while (!axi.axi_arready && n < 20);
    if (!axi.axi_arready) begin
      total++; bad++;
      $display("FAIL read_timeout addr=%h got no arready, required ack", a);
    end
    tick();
    axi.axi_arvalid = 1'b0;
    total++;
    if (axi.axi_rvalid !== 1'b1) begin
      bad++; $display("FAIL read_rvalid addr=%h got %b required 1", a, axi.axi_rvalid);
    end
    d = axi.axi_rdata;
    axi.axi_rready = 1'b1;
    tick();
    axi.axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    axi.axi_awvalid = 0; axi.axi_wvalid = 0; axi.axi_arvalid = 0; axi.axi_rready = 0;
    axi.axi_awaddr = '0; axi.axi_araddr = '0; axi.axi_wdata = '0; axi.axi_wstrb = '0;
    axi_reset_n = 1'b0;
    tick(); tick();
    total++;
    if ({axi.axi_awready, axi.axi_wready, axi.axi_arready, axi.axi_rvalid, cfg_wr_pulse} !== 5'b0
        || axi.axi_rdata !== 32'h0 || cfg_ctrl !== 32'h0) begin
      bad++; $display("FAIL reset_outputs got rdy/vld=%b rdata=%h ctrl=%h required all 0",
        {axi.axi_awready, axi.axi_wready, axi.axi_arready, axi.axi_rvalid, cfg_wr_pulse},
        axi.axi_rdata, cfg_ctrl);
    end
    axi_reset_n = 1'b1;
    cc_enable = 1'b1;
    tick();
    do_read(15'h008, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_scratch got %h required 0", d); end
    do_read(15'h00C, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_wrcnt got %h required 0", d); end
  endtask

  task automatic test_ctrl_write();
    logic [31:0] d;
    axi.axi_awaddr = 15'h000; axi.axi_wdata = 32'hA5A5_1234; axi.axi_wstrb = 4'hF;
    axi.axi_awvalid = 1'b1; axi.axi_wvalid = 1'b1;
    tick();
    total++;
    if (axi.axi_awready !== 1'b1 || axi.axi_wready !== 1'b1) begin
      bad++; $display("FAIL ctrl_ack got aw=%b w=%b required 1 1", axi.axi_awready, axi.axi_wready);
    end
    tick();
    axi.axi_awvalid = 1'b0; axi.axi_wvalid = 1'b0;
    total++;
    if (axi.axi_awready !== 1'b0 || axi.axi_wready !== 1'b0) begin
      bad++; $display("FAIL ctrl_ack_width got aw=%b w=%b required 0 0", axi.axi_awready, axi.axi_wready);
    end
    total++;
    if (cfg_ctrl !== 32'hA5A5_1234) begin bad++; $display("FAIL ctrl_value got %h required a5a51234", cfg_ctrl); end
    total++;
    if (cfg_wr_pulse !== 1'b1) begin bad++; $display("FAIL ctrl_pulse got %b required 1", cfg_wr_pulse); end
    tick();
    total++;
    if (cfg_wr_pulse !== 1'b0) begin bad++; $display("FAIL ctrl_pulse_width got %b required 0", cfg_wr_pulse); end
    do_read(15'h00C, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL ctrl_wrcnt got %h required 1", d); end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    do_write(15'h000, 32'hFFFF_FFFF, 4'h5);
    total++;
    if (cfg_ctrl !== 32'hA5FF_12FF) begin bad++; $display("FAIL strobe_5 got %h required a5ff12ff", cfg_ctrl); end
    do_write(15'h000, 32'h0000_0000, 4'h0);
    total++;
    if (cfg_ctrl !== 32'hA5FF_12FF) begin bad++; $display("FAIL strobe_0 got %h required a5ff12ff", cfg_ctrl); end
    do_read(15'h00C, d);
    total++;
    if (d !== 32'h3) begin bad++; $display("FAIL strobe_wrcnt got %h required 3", d); end
    sts_in = 32'h1234_5678;
    do_read(15'h004, d);
    total++;
    if (d !== 32'h1234_5678) begin bad++; $display("FAIL status_read got %h required 12345678", d); end
  endtask

  task automatic test_read_stall();
    logic stable_ok = 1'b1;
    do_write(15'h008, 32'hDEAD_BEEF, 4'hF);
    axi.axi_araddr = 15'h008; axi.axi_arvalid = 1'b1;
    tick();
    total++;
    if (axi.axi_arready !== 1'b1 || axi.axi_rvalid !== 1'b0) begin
      bad++; $display("FAIL stall_arready got ar=%b rv=%b required 1 0", axi.axi_arready, axi.axi_rvalid);
    end
    tick();
    axi.axi_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (axi.axi_arready !== 1'b0 || axi.axi_rvalid !== 1'b1 || axi.axi_rdata !== 32'hDEAD_BEEF) stable_ok = 1'b0;
      if (i < 4) tick();
    end
    total++;
    if (stable_ok !== 1'b1) begin
      bad++; $display("FAIL stall_hold got rv=%b rdata=%h required 1 deadbeef", axi.axi_rvalid, axi.axi_rdata);
    end
    axi.axi_rready = 1'b1;
    tick();
    axi.axi_rready = 1'b0;
    total++;
    if (axi.axi_rvalid !== 1'b0 || axi.axi_rdata !== 32'h0) begin
      bad++; $display("FAIL stall_release got rv=%b rdata=%h required 0 0", axi.axi_rvalid, axi.axi_rdata);
    end
  endtask

  task automatic test_partial_valid();
    logic seen = 1'b0;
    logic [31:0] d;
    axi.axi_awaddr = 15'h008; axi.axi_wdata = 32'h1111_2222; axi.axi_wstrb = 4'hF;
    axi.axi_awvalid = 1'b1; axi.axi_wvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (axi.axi_awready || axi.axi_wready) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL aw_only_ack got ready=1 required 0"); end
    axi.axi_wvalid = 1'b1;
    tick();
    total++;
    if (axi.axi_awready !== 1'b1 || axi.axi_wready !== 1'b1) begin
      bad++; $display("FAIL aw_then_w_ack got aw=%b w=%b required 1 1", axi.axi_awready, axi.axi_wready);
    end
    tick();
    axi.axi_awvalid = 1'b0; axi.axi_wvalid = 1'b0;
    cc_enable = 1'b0;
    axi.axi_wdata = 32'h9999_9999;
    axi.axi_awvalid = 1'b1; axi.axi_wvalid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (axi.axi_awready || axi.axi_wready) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL disabled_ack got ready=1 required 0"); end
    axi.axi_awvalid = 1'b0; axi.axi_wvalid = 1'b0;
    cc_enable = 1'b1;
    tick();
    do_read(15'h008, d);
    total++;
    if (d !== 32'h1111_2222) begin bad++; $display("FAIL partial_scratch got %h required 11112222", d); end
    do_read(15'h00C, d);
    total++;
    if (d !== 32'h5) begin bad++; $display("FAIL partial_wrcnt got %h required 5", d); end
  endtask

  task automatic test_concurrent();
    logic [31:0] d;
    axi.axi_awaddr = 15'h008; axi.axi_wdata = 32'h3333_4444; axi.axi_wstrb = 4'hF;
    axi.axi_araddr = 15'h008;
    axi.axi_awvalid = 1'b1; axi.axi_wvalid = 1'b1; axi.axi_arvalid = 1'b1;
    tick();
    cc_enable = 1'b0;
    total++;
    if (axi.axi_awready !== 1'b1 || axi.axi_arready !== 1'b1) begin
      bad++; $display("FAIL conc_ack got aw=%b ar=%b required 1 1", axi.axi_awready, axi.axi_arready);
    end
    tick();
    axi.axi_awvalid = 1'b0; axi.axi_wvalid = 1'b0; axi.axi_arvalid = 1'b0;
    total++;
    if (axi.axi_rvalid !== 1'b1 || axi.axi_rdata !== 32'h1111_2222) begin
      bad++; $display("FAIL conc_old_value got rv=%b rdata=%h required 1 11112222", axi.axi_rvalid, axi.axi_rdata);
    end
    axi.axi_rready = 1'b1;
    tick();
    axi.axi_rready = 1'b0;
    cc_enable = 1'b1;
    do_read(15'h008, d);
    total++;
    if (d !== 32'h3333_4444) begin bad++; $display("FAIL conc_new_value got %h required 33334444", d); end
  endtask

  task automatic test_wrcnt();
    logic [31:0] d;
    force dut.wr_cnt_q = 16'hFFFF;
    #1;
    release dut.wr_cnt_q;
    do_read(15'h00C, d);
    total++;
    if (d !== 32'h0000_FFFF) begin bad++; $display("FAIL wrcnt_preset got %h required 0000ffff", d); end
    do_write(15'h1008, 32'h0000_0055, 4'hF);
    do_read(15'h00C, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL wrcnt_wrap got %h required 0", d); end
    do_read(15'h00B, d);
    total++;
    if (d !== 32'h55) begin bad++; $display("FAIL alias_scratch got %h required 55", d); end
    do_write(15'h7F0, 32'hFFFF_FFFF, 4'hF);
    do_read(15'h00C, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL wrcnt_unmapped_write got %h required 1", d); end
    do_read(15'h7F0, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL unmapped_read got %h required 0", d); end
    do_write(15'h00C, 32'h0000_0000, 4'h0);
    do_read(15'h00C, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL wrcnt_clear got %h required 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    axi.axi_araddr = 15'h008; axi.axi_arvalid = 1'b1;
    tick(); tick();
    axi.axi_arvalid = 1'b0;
    axi.axi_awaddr = 15'h000; axi.axi_wdata = 32'h0F0F_0F0F; axi.axi_wstrb = 4'hF;
    axi.axi_awvalid = 1'b1; axi.axi_wvalid = 1'b1;
    tick();
    total++;
    if (axi.axi_awready !== 1'b1 || axi.axi_rvalid !== 1'b1 || axi.axi_rdata !== 32'h55) begin
      bad++; $display("FAIL midrst_setup got aw=%b rv=%b rdata=%h required 1 1 55",
        axi.axi_awready, axi.axi_rvalid, axi.axi_rdata);
    end
    #2 axi_reset_n = 1'b0;
    #1;
    total++;
    if ({axi.axi_awready, axi.axi_wready, axi.axi_arready, axi.axi_rvalid, cfg_wr_pulse} !== 5'b0
        || axi.axi_rdata !== 32'h0 || cfg_ctrl !== 32'h0) begin
      bad++; $display("FAIL midrst_outputs got rdy/vld=%b rdata=%h ctrl=%h required all 0",
        {axi.axi_awready, axi.axi_wready, axi.axi_arready, axi.axi_rvalid, cfg_wr_pulse},
        axi.axi_rdata, cfg_ctrl);
    end
    axi.axi_awvalid = 1'b0; axi.axi_wvalid = 1'b0;
    tick(); tick();
    axi_reset_n = 1'b1;
    tick();
    total++;
    if (cfg_ctrl !== 32'h0) begin bad++; $display("FAIL midrst_ctrl got %h required 0", cfg_ctrl); end
    do_read(15'h000, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL midrst_ctrl_read got %h required 0", d); end
    do_read(15'h008, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL midrst_scratch got %h required 0", d); end
    do_read(15'h00C, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL midrst_wrcnt got %h required 0", d); end
  endtask

  initial begin
    test_reset();
    test_ctrl_write();
    test_strobe();
    test_read_stall();
    test_partial_valid();
    test_concurrent();
    test_wrcnt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
